// File: rtl/tmds_video_scheduler.sv
// Raster timing generator and pixel-source scheduler for the three TMDS encoders.
// Timing is delayed by PIPE cycles so control and enable line up with the returned pixels.
module tmds_video_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_underflow,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic        pix_valid,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [7:0]  vd_r,
  output logic [7:0]  vd_g,
  output logic [7:0]  vd_b,
  output logic [1:0]  cd_b,
  output logic [1:0]  cd_g,
  output logic [1:0]  cd_r,
  output logic        vde,
  output logic        frame_start,
  output logic        underflow,
  output logic        busy
);

  // state  | meaning
  // S_IDLE | counters parked at 0, no requests, waiting for en
  // S_RUN  | counters advance every cycle; en re-sampled at the last pixel of a frame
  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic f0;
  } tim_t;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  tim_t        dl_q [PIPE];
  tim_t        dl_d [PIPE];
  tim_t        cur;
  tim_t        dly;
  logic        run;

  logic [7:0]  vd_r_q, vd_r_d;
  logic [7:0]  vd_g_q, vd_g_d;
  logic [7:0]  vd_b_q, vd_b_d;
  logic [1:0]  cd_b_q, cd_b_d;
  logic        vde_q, vde_d;
  logic        frame_start_q, frame_start_d;
  logic        underflow_q, underflow_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!en) state_d = S_IDLE;
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end
    endcase
  end

  assign run = (state_q == S_RUN);

  // Blanking values are produced in IDLE so the delay line flushes on its own.
  always_comb begin
    cur.act = run && (h_q < H_ACT) && (v_q < V_ACT);
    cur.hs  = run && (h_q >= HS_START) && (h_q < HS_END);
    cur.vs  = run && (v_q >= VS_START) && (v_q < VS_END);
    cur.f0  = run && (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    dl_d[0] = cur;
    for (int i = 1; i < PIPE; i++) dl_d[i] = dl_q[i-1];
  end

  assign dly = dl_q[PIPE-1];

  always_comb begin
    vd_r_d        = '0;
    vd_g_d        = '0;
    vd_b_d        = '0;
    vde_d         = dly.act;
    frame_start_d = dly.f0;
    cd_b_d        = {(dly.vs ? VS_POL : ~VS_POL), (dly.hs ? HS_POL : ~HS_POL)};
    if (dly.act && pix_valid) begin
      vd_r_d = pix_r;
      vd_g_d = pix_g;
      vd_b_d = pix_b;
    end
    // A miss in the same cycle as a clear must leave the flag set.
    underflow_d = (dly.act && !pix_valid) || (underflow_q && !clr_underflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      for (int i = 0; i < PIPE; i++) dl_q[i] <= '0;
      vd_r_q        <= '0;
      vd_g_q        <= '0;
      vd_b_q        <= '0;
      cd_b_q        <= {~VS_POL, ~HS_POL};
      vde_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      for (int i = 0; i < PIPE; i++) dl_q[i] <= dl_d[i];
      vd_r_q        <= vd_r_d;
      vd_g_q        <= vd_g_d;
      vd_b_q        <= vd_b_d;
      cd_b_q        <= cd_b_d;
      vde_q         <= vde_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pix_req     = cur.act;
  assign pix_x       = cur.act ? h_q : 12'd0;
  assign pix_y       = cur.act ? v_q : 12'd0;
  assign busy        = run;
  assign vd_r        = vd_r_q;
  assign vd_g        = vd_g_q;
  assign vd_b        = vd_b_q;
  assign cd_b        = cd_b_q;
  assign cd_g        = 2'b00;
  assign cd_r        = 2'b00;
  assign vde         = vde_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_tmds_video_scheduler.sv
// Scoreboard bench for tmds_video_scheduler: a frame-position reference model pushes
// expected outputs into queues, a negedge monitor pops and compares them.
module tb_tmds_video_scheduler;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int PIPE = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr_underflow = 1'b0;
  logic        pix_req;
  logic [11:0] pix_x, pix_y;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic [7:0]  vd_r, vd_g, vd_b;
  logic [1:0]  cd_b, cd_g, cd_r;
  logic        vde, frame_start, underflow, busy;

  tmds_video_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr_underflow(clr_underflow),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .vd_r(vd_r), .vd_g(vd_g), .vd_b(vd_b),
    .cd_b(cd_b), .cd_g(cd_g), .cd_r(cd_r),
    .vde(vde), .frame_start(frame_start), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; bit act; bit hs; bit vs; bit f0;
  } tim_t;

  typedef struct {
    int tag; bit req; int x; int y; bit busy;
  } comb_t;

  typedef struct {
    int tag; int r; int g; int b; bit vde; int cd; bit fs; bit uf;
  } reg_t;

  tim_t  tq[$];
  comb_t comb_q[$];
  reg_t  reg_q[$];

  bit m_run;
  int m_p;
  bit m_uf;
  int cyc;
  int checks;
  int errors;
  bit force_drop;
  bit clr_on_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic tim_t model_tim();
    tim_t t;
    t.h   = m_run ? m_p % HT : 0;
    t.v   = m_run ? m_p / HT : 0;
    t.act = m_run && t.h < HA && t.v < VA;
    t.hs  = m_run && t.h >= HA + HF && t.h < HA + HF + HSW;
    t.vs  = m_run && t.v >= VA + VF && t.v < VA + VF + VSW;
    t.f0  = m_run && m_p == 0;
    return t;
  endfunction

  task automatic model_reset();
    tim_t blank;
    blank = '{default: 0};
    comb_q.delete();
    reg_q.delete();
    tq.delete();
    for (int i = 0; i < PIPE; i++) tq.push_back(blank);
    m_run = 1'b0;
    m_p   = 0;
    m_uf  = 1'b0;
  endtask

  task automatic step(input bit en_i, input bit clr_i, input int valid_pct);
    tim_t  t, old;
    comb_t c;
    reg_t  r;
    bit    vld;
    bit    clr;
    @(posedge clk);
    cyc++;
    #1;
    t = model_tim();
    c.tag  = cyc;
    c.req  = t.act;
    c.x    = t.act ? t.h : 0;
    c.y    = t.act ? t.v : 0;
    c.busy = m_run;
    comb_q.push_back(c);

    tq.push_back(t);
    old = tq.pop_front();
    vld = (int'($urandom_range(99)) < valid_pct);
    clr = clr_i;
    if (force_drop && old.act && old.h == 2 && old.v == 1) begin
      vld = 1'b0;
      if (clr_on_drop) clr = 1'b1;
    end
    en            = en_i;
    clr_underflow = clr;
    pix_valid     = vld;
    pix_r         = old.act ? 8'(old.h) : 8'($urandom);
    pix_g         = old.act ? 8'(old.v) : 8'($urandom);
    pix_b         = 8'($urandom);

    m_uf  = (old.act && !vld) || (m_uf && !clr);
    r.tag = cyc + 1;
    r.r   = (old.act && vld) ? int'(pix_r) : 0;
    r.g   = (old.act && vld) ? int'(pix_g) : 0;
    r.b   = (old.act && vld) ? int'(pix_b) : 0;
    r.vde = old.act;
    r.cd  = {30'd0, !old.vs, !old.hs};
    r.fs  = old.f0;
    r.uf  = m_uf;
    reg_q.push_back(r);

    if (!m_run) begin
      if (en_i) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else if (m_p == FT - 1) begin
      m_p = 0;
      if (!en_i) m_run = 1'b0;
    end else begin
      m_p++;
    end
  endtask

  task automatic pulse_reset();
    #2;
    rst           = 1'b1;
    en            = 1'b0;
    clr_underflow = 1'b0;
    pix_valid     = 1'b0;
    #1;
    chk("rst_vde",       32'(vde),       32'd0);
    chk("rst_cd_b",      32'(cd_b),      32'd3);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_pix_req",   32'(pix_req),   32'd0);
    chk("rst_fstart",    32'(frame_start), 32'd0);
    chk("rst_vd_r",      32'(vd_r),      32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : monitor
    comb_t c;
    reg_t  r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (comb_q.size() > 0 && comb_q[0].tag == cyc) begin
          c = comb_q.pop_front();
          chk("pix_req", 32'(pix_req), 32'(c.req));
          chk("pix_x",   32'(pix_x),   32'(c.x));
          chk("pix_y",   32'(pix_y),   32'(c.y));
          chk("busy",    32'(busy),    32'(c.busy));
        end
        if (reg_q.size() > 0 && reg_q[0].tag == cyc) begin
          r = reg_q.pop_front();
          chk("vd_r",        32'(vd_r),        32'(r.r));
          chk("vd_g",        32'(vd_g),        32'(r.g));
          chk("vd_b",        32'(vd_b),        32'(r.b));
          chk("vde",         32'(vde),         32'(r.vde));
          chk("cd_b",        32'(cd_b),        32'(r.cd));
          chk("cd_gr",       32'({cd_g, cd_r}), 32'd0);
          chk("frame_start", 32'(frame_start), 32'(r.fs));
          chk("underflow",   32'(underflow),   32'(r.uf));
        end
      end
    end
  end

  initial begin : driver
    bit stopped;
    checks = 0;
    errors = 0;
    cyc    = 0;
    force_drop  = 1'b0;
    clr_on_drop = 1'b0;
    model_reset();
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 100);

    // start, drop pixel (2,1), request stop mid-frame at h=3,v=1
    force_drop = 1'b1;
    stopped    = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (m_run && m_p == HT + 3) stopped = 1'b1;
      step(!stopped, 1'b0, 100);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 100);
    step(1'b0, 1'b1, 100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 100);

    // three back-to-back frames; the miss coincides with a clear
    clr_on_drop = 1'b1;
    for (int i = 0; i < 140; i++) step(1'b1, 1'b0, 100);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 100);
    clr_on_drop = 1'b0;
    force_drop  = 1'b0;

    // randomized run, aborted by a reset mid-stream
    for (int i = 0; i < 300; i++)
      step(int'($urandom_range(99)) < 70, int'($urandom_range(99)) < 5, 90);
    while (!(m_run && m_p > 10 && m_p < 40)) step(1'b1, 1'b0, 90);
    pulse_reset();
    for (int i = 0; i < 200; i++)
      step(int'($urandom_range(99)) < 60, int'($urandom_range(99)) < 8, 85);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 100);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_video_scheduler.md
# tmds_video_scheduler

Sequences the three per-channel TMDS encoders of the HDMI output path. Generates raster timing (counters, hsync/vsync, data-enable) and requests pixels from an upstream pixel source at a fixed, parameterised read latency. Delays the timing signals to realign them with the returned pixel data. Drives each encoder's video data, control data and video-data-enable inputs as registered outputs, and substitutes black with a sticky underflow flag when the source misses a pixel.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- PIPE, 2, pixel source read latency in cycles (1..8)

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; sampled only at frame boundaries
- clr_underflow  in  1  clears the underflow flag
- pix_req  out  1  pixel request; high while the counters are in the active region
- pix_x  out  12  requested column
- pix_y  out  12  requested row
- pix_valid  in  1  returned data valid, PIPE cycles after pix_req
- pix_r, pix_g, pix_b  in  8 each  returned pixel
- vd_r, vd_g, vd_b  out  8 each  video data to the red, green and blue encoders
- cd_b  out  2  blue-channel control data, {vsync, hsync}
- cd_g, cd_r  out  2 each  green and red control data; always 0
- vde  out  1  video data enable, common to all three encoders
- frame_start  out  1  one-cycle pulse on the first output cycle of pixel (0,0)
- underflow  out  1  sticky flag: an active pixel was missed
- busy  out  1  high while in RUN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = the vertical equivalent. Both must be ≤ 4095.
- Counters h and v are 12 bits. h wraps from H_TOTAL-1 to 0. v increments on each h wrap and wraps from V_TOTAL-1 to 0.
- The active region is h<H_ACTIVE && v<V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines, with the same start as line start.
- Asserted level is HS_POL/VS_POL; the deasserted level is the inverse.
- State machine with two states:
  - IDLE: counters held at 0, pix_req=0, busy=0. If en=1, go to RUN; the first RUN cycle has h=v=0.
  - RUN: counters advance every cycle. At h=H_TOTAL-1, v=V_TOTAL-1, go to IDLE if en=0; otherwise wrap and stay in RUN.
  - Dropping en mid-frame always completes the frame.
- pix_req, pix_x and pix_y are driven directly from registered state (no combinational input paths). pix_x=h and pix_y=v when pix_req=1; both are 0 otherwise.
- Timing delay line: {active, hsync, vsync, frame0} is delayed by PIPE stages. The line keeps shifting in IDLE, feeding blanking values (inactive, syncs deasserted), so the outputs flush cleanly.
- Output register update each cycle:
  - Delayed active=1, pix_valid=1: vd = pix, vde=1.
  - Delayed active=1, pix_valid=0: vd=0, vde=1, underflow is set.
  - Delayed active=0: vd=0, vde=0, and pix_valid is ignored.
  - cd_b = delayed {vsync, hsync} in every case.
- underflow: a set and a clr_underflow in the same cycle leaves the flag set.

## Timing
- Reset values (immediate, asynchronous): state IDLE, h=v=0, delay line blank, pix_req=0, pix_x=pix_y=0, vd_*=0, vde=0, cd_b={~VS_POL,~HS_POL}, cd_g=cd_r=0, frame_start=0, underflow=0, busy=0.
- A reset asserted mid-frame aborts the frame. Once reset is released, the block waits in IDLE for en.
- Counter state at cycle n:
  - pix_req, pix_x and pix_y are valid in cycle n.
  - The source answers in cycle n+PIPE.
  - vd, vde, cd and frame_start are valid in cycle n+PIPE+1.
  - The encoders add one further cycle.
- en=1 in IDLE at cycle k: RUN with h=0 at k+1, and the first pix_req at k+1.
- frame_start is high for exactly one cycle per frame.
- busy is high from the first RUN cycle through the last counter cycle of the final frame.

## Test plan
All scenarios use small parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), PIPE=2, HS_POL=VS_POL=0.
- Reset check: pulse rst at any point -> vde=0, cd_b=2'b11, underflow=0, busy=0, pix_req=0, all within the same cycle.
- Start and pixel stream: en=1 at cycle k, source echoes pix_r=pix_x, always valid ->
  - pix_req high at k+1..k+4 with pix_x 0,1,2,3;
  - vde high at k+4..k+7 with vd_r 0,1,2,3;
  - frame_start at k+4;
  - line period 8.
- Sync placement: in RUN ->
  - cd_b[0]=0 exactly at output cycles corresponding to h=5,6;
  - cd_b[1]=0 for the whole of line v=4 (8 cycles);
  - both 1 elsewhere.
- Underflow: drop pix_valid for pixel (2,1) -> vd=0 with vde=1 in that cycle, underflow=1 and it stays set. Pulse clr_underflow -> 0. Set and clear in the same cycle -> stays 1.
- Stop handling: en low at h=3, v=1 -> the frame completes (48 cycles from start), IDLE entered, busy falls. The outputs flush blanking, no further pix_req, cd_b=2'b11.
- Continuous run: en held high for 3 frames -> frame_start every 48 cycles, 12 vde cycles per frame, no gaps at the frame wrap.
